// File: rtl/seg_serial_adder.sv
// seg_serial_adder: multi-cycle WIDTH-bit adder/subtractor that handles SEG bits per clock
// through a single SEG-bit ripple segment, with the carry held in a register between segments.
// Result flags (sum/cout/ovf/zero) update only when an operation completes.
module seg_serial_adder #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned N     = WIDTH / SEG;
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(N - 1);

  typedef enum logic {StIdle, StBusy} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;       // b already inverted for subtraction
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  int unsigned      seg_base;
  logic [SEG-1:0]   seg_a, seg_b, seg_sum;
  logic             seg_cout;
  logic             last_seg;

  // Select the current segment of the latched operands and add it with the held carry.
  always_comb begin
    seg_base             = 32'(idx_q) * SEG;
    seg_a                = a_q[seg_base +: SEG];
    seg_b                = b_q[seg_base +: SEG];
    {seg_cout, seg_sum}  = {1'b0, seg_a} + {1'b0, seg_b} + (SEG + 1)'(carry_q);
    last_seg             = (idx_q == LastIdx);
  end

  // Next-state and datapath control; published results move only on the final segment.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    carry_d = carry_q;
    res_d   = res_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          idx_d   = '0;
          state_d = StBusy;
        end
      end
      StBusy: begin
        res_d[seg_base +: SEG] = seg_sum;
        carry_d                = seg_cout;
        if (last_seg) begin
          idx_d   = '0;
          sum_d   = res_d;
          cout_d  = seg_cout;
          // Same-sign operands producing an opposite-sign result is a signed overflow.
          ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
          zero_d  = (res_d == '0);
          done_d  = 1'b1;
          state_d = StIdle;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      res_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q == StBusy);
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_seg_serial_adder.sv
// Bench for seg_serial_adder: four 32-bit instances (SEG = 8, 1, 4, 32) checked through
// per-instance scoreboards, plus an 8-bit single-segment instance checked directly.
module tb_seg_serial_adder;

  localparam int NI = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        zero;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NI-1:0] start_v;
  logic          sub, cin;
  logic [31:0]   a, b;
  logic [NI-1:0] busy_w, done_w, cout_w, ovf_w, zero_w;
  logic [31:0]   sum_w [NI];

  logic          start8, sub8, cin8;
  logic [7:0]    a8, b8;
  logic          busy8, done8, cout8, ovf8, zero8;
  logic [7:0]    sum8;

  exp_t          q [NI][$];
  int            n_tests = 0;
  int            n_fail  = 0;

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Whole-word reference: plain add with carry, or true subtraction with borrow.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y,
                                 input logic c, input logic s);
    exp_t        e;
    logic [32:0] r;
    if (s) begin
      r      = {1'b0, x} - {1'b0, y};
      e.cout = ~r[32];
      e.ovf  = (x[31] != y[31]) && (r[31] != x[31]);
    end else begin
      r      = {1'b0, x} + {1'b0, y} + {32'd0, c};
      e.cout = r[32];
      e.ovf  = (x[31] == y[31]) && (r[31] != x[31]);
    end
    e.sum  = r[31:0];
    e.zero = (r[31:0] == 32'd0);
    return e;
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int unsigned S = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
    int dcnt = 0;

    seg_serial_adder #(.WIDTH(32), .SEG(S)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start_v[g]),
      .sub   (sub),
      .a     (a),
      .b     (b),
      .cin   (cin),
      .busy  (busy_w[g]),
      .done  (done_w[g]),
      .sum   (sum_w[g]),
      .cout  (cout_w[g]),
      .ovf   (ovf_w[g]),
      .zero  (zero_w[g])
    );

    // Scoreboard monitor: every done pops and compares one expected result.
    always @(negedge clk) begin
      exp_t e;
      if (rst_n && done_w[g]) begin
        dcnt++;
        if (q[g].size() == 0) begin
          check($sformatf("s%0d_spurious_done", S), 64'd1, 64'd0);
        end else begin
          e = q[g].pop_front();
          check($sformatf("s%0d_sum", S), 64'(sum_w[g]), 64'(e.sum));
          check($sformatf("s%0d_flags", S), {cout_w[g], ovf_w[g], zero_w[g]},
                {e.cout, e.ovf, e.zero});
        end
      end
    end
  end

  seg_serial_adder #(.WIDTH(8), .SEG(8)) u_dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start8),
    .sub   (sub8),
    .a     (a8),
    .b     (b8),
    .cin   (cin8),
    .busy  (busy8),
    .done  (done8),
    .sum   (sum8),
    .cout  (cout8),
    .ovf   (ovf8),
    .zero  (zero8)
  );

  task automatic launch(input int g, input logic [31:0] x, input logic [31:0] y,
                        input logic c, input logic s);
    a          = x;
    b          = y;
    cin        = c;
    sub        = s;
    start_v[g] = 1'b1;
    q[g].push_back(model(x, y, c, s));
  endtask

  // Runs one op on the SEG=8 instance, checking latency, busy and result stability.
  // Returns #1 after the done edge, so the next call starts back-to-back in the done cycle.
  task automatic timed_op(input logic [31:0] x, input logic [31:0] y,
                          input logic c, input logic s);
    logic [31:0] hold;
    int          lat;
    launch(0, x, y, c, s);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    hold       = sum_w[0];
    a          = $urandom;
    b          = $urandom;
    cin        = ~c;
    sub        = ~s;
    check("busy_after_start", 64'(busy_w[0]), 64'd1);
    lat = 0;
    while (lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (done_w[0]) break;
      check("sum_stable", 64'(sum_w[0]), 64'(hold));
    end
    check("latency", 64'(lat), 64'd4);
    check("busy_at_done", 64'(busy_w[0]), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int d0, cnt;
    logic [31:0] x, y;
    logic c, s;

    rst_n   = 1'b0;
    start_v = '0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {busy_w[0], done_w[0], cout_w[0], ovf_w[0], zero_w[0], sum_w[0]},
          64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases, each started in the previous done cycle.
    timed_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
    timed_op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0);
    timed_op(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    timed_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    timed_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
    timed_op(32'h0000_1234, 32'h0000_1234, 1'b1, 1'b1);
    start_v[0] = 1'b0;

    // Start held through busy cycles 1 and 2 with other operands: must be ignored.
    repeat (2) @(negedge clk);
    d0 = g_dut[0].dcnt;
    launch(0, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b0);
    @(posedge clk); #1;
    a = 32'hDEAD_BEEF; b = 32'h1111_1111;
    @(posedge clk); #1;
    a = 32'h0BAD_F00D; sub = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    repeat (8) @(negedge clk);
    check("ignored_start_one_done", 64'(g_dut[0].dcnt - d0), 64'd1);
    check("ignored_start_queue", 64'(q[0].size()), 64'd0);

    // Reset in cycle 2 of an operation aborts it without a done.
    @(negedge clk);
    d0 = g_dut[0].dcnt;
    launch(0, 32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0);
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {busy_w[0], done_w[0], cout_w[0], ovf_w[0], zero_w[0], sum_w[0]},
          64'd0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("abort_no_done", 64'(g_dut[0].dcnt - d0), 64'd0);
    check("abort_outputs_hold", {busy_w[0], cout_w[0], ovf_w[0], zero_w[0], sum_w[0]}, 64'd0);
    for (int g = 0; g < NI; g++) q[g].delete();

    // Single-segment 8-bit instance: done one cycle after start, back-to-back.
    @(negedge clk);
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("n1_busy", 64'(busy8), 64'd1);
    @(posedge clk); #1;
    check("n1_done", 64'(done8), 64'd1);
    check("n1_result", {cout8, ovf8, zero8, sum8}, {3'b010, 8'h80});
    a8 = 8'h01; b8 = 8'hFF; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    check("n1_b2b_busy", {busy8, done8}, 2'b10);
    @(posedge clk); #1;
    check("n1_b2b_done", 64'(done8), 64'd1);
    check("n1_b2b_result", {cout8, ovf8, zero8, sum8}, {3'b101, 8'h00});

    // Random operands on all four 32-bit instances at once.
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      x = $urandom;
      y = $urandom;
      c = 1'($urandom_range(0, 1));
      s = 1'($urandom_range(0, 1));
      if (i % 7 == 0) y = s ? x : ~x;
      for (int g = 0; g < NI; g++) launch(g, x, y, c, s);
      @(posedge clk); #1;
      start_v = '0;
      cnt = 0;
      while (busy_w != '0 && cnt < 40) begin
        @(posedge clk); #1;
        cnt++;
      end
      if (cnt >= 40) check("random_timeout", 64'(busy_w), 64'd0);
      @(negedge clk);
    end

    repeat (4) @(negedge clk);
    for (int g = 0; g < NI; g++) check("queue_drained", 64'(q[g].size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
